// File: rtl/cmplx_mul_pipe.sv
// Pipelined complex multiplier {re,im} x {re,im} with optional conj(b), rounding and saturation.
// Operand capture, multiply, combine and scale stages share one stall enable driven by the output side.
module cmplx_mul_pipe #(
  parameter int W     = 32,
  parameter int P     = 16,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  input  logic           conj_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           ovf,
  output logic           ovf_sticky,
  input  logic           clr
);

  localparam logic signed [2*W:0] C_ONE  = {{(2*W){1'b0}}, 1'b1};
  localparam logic signed [2*W:0] C_HALF = (ROUND != 0) ? (C_ONE <<< (P-1)) : '0;
  localparam logic signed [2*W:0] C_MAX  = (C_ONE <<< (W-1)) - C_ONE;
  localparam logic signed [2*W:0] C_MIN  = -(C_ONE <<< (W-1));

  logic w_en;

  logic           r_s0_v;
  logic           r_s0_conj;
  logic [2*W-1:0] r_s0_a;
  logic [2*W-1:0] r_s0_b;

  logic                  r_s1_v;
  logic                  r_s1_conj;
  logic signed [2*W-1:0] r_rr, r_ii, r_ri, r_ir;

  logic                r_s2_v;
  logic signed [2*W:0] r_re2, r_im2;

  logic           r_s3_v;
  logic [2*W-1:0] r_res;
  logic           r_ovf;
  logic           r_sticky;

  logic signed [2*W-1:0] w_ar, w_ai, w_br, w_bi;
  logic signed [2*W-1:0] w_rr, w_ii, w_ri, w_ir;
  logic signed [2*W:0]   w_rr_x, w_ii_x, w_ri_x, w_ir_x;
  logic signed [2*W:0]   w_re2, w_im2;
  logic signed [2*W:0]   w_re_rnd, w_im_rnd, w_re_sh, w_im_sh;
  logic                  w_re_hi, w_re_lo, w_im_hi, w_im_lo;
  logic [W-1:0]          w_re_q, w_im_q;
  logic                  w_ovf3;

  assign w_en     = !r_s3_v || out_ready;
  assign in_ready = w_en;

  // Components sign-extended to 2W so the multiply is exact at product width.
  assign w_ar = {{W{r_s0_a[2*W-1]}}, r_s0_a[2*W-1:W]};
  assign w_ai = {{W{r_s0_a[W-1]}},   r_s0_a[W-1:0]};
  assign w_br = {{W{r_s0_b[2*W-1]}}, r_s0_b[2*W-1:W]};
  assign w_bi = {{W{r_s0_b[W-1]}},   r_s0_b[W-1:0]};

  assign w_rr = w_ar * w_br;
  assign w_ii = w_ai * w_bi;
  assign w_ri = w_ar * w_bi;
  assign w_ir = w_ai * w_br;

  assign w_rr_x = {r_rr[2*W-1], r_rr};
  assign w_ii_x = {r_ii[2*W-1], r_ii};
  assign w_ri_x = {r_ri[2*W-1], r_ri};
  assign w_ir_x = {r_ir[2*W-1], r_ir};

  assign w_re2 = r_s1_conj ? (w_rr_x + w_ii_x) : (w_rr_x - w_ii_x);
  assign w_im2 = r_s1_conj ? (w_ir_x - w_ri_x) : (w_ri_x + w_ir_x);

  assign w_re_rnd = r_re2 + C_HALF;
  assign w_im_rnd = r_im2 + C_HALF;
  assign w_re_sh  = w_re_rnd >>> P;
  assign w_im_sh  = w_im_rnd >>> P;

  assign w_re_hi = w_re_sh > C_MAX;
  assign w_re_lo = w_re_sh < C_MIN;
  assign w_im_hi = w_im_sh > C_MAX;
  assign w_im_lo = w_im_sh < C_MIN;

  assign w_re_q = ((SAT != 0) && w_re_hi) ? C_MAX[W-1:0] :
                  ((SAT != 0) && w_re_lo) ? C_MIN[W-1:0] : w_re_sh[W-1:0];
  assign w_im_q = ((SAT != 0) && w_im_hi) ? C_MAX[W-1:0] :
                  ((SAT != 0) && w_im_lo) ? C_MIN[W-1:0] : w_im_sh[W-1:0];
  assign w_ovf3 = w_re_hi || w_re_lo || w_im_hi || w_im_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_v    <= 1'b0;
      r_s0_conj <= 1'b0;
      r_s0_a    <= '0;
      r_s0_b    <= '0;
      r_s1_v    <= 1'b0;
      r_s1_conj <= 1'b0;
      r_rr      <= '0;
      r_ii      <= '0;
      r_ri      <= '0;
      r_ir      <= '0;
      r_s2_v    <= 1'b0;
      r_re2     <= '0;
      r_im2     <= '0;
      r_s3_v    <= 1'b0;
      r_res     <= '0;
      r_ovf     <= 1'b0;
    end else if (w_en) begin
      r_s0_v    <= in_valid;
      r_s0_conj <= conj_b;
      r_s0_a    <= a;
      r_s0_b    <= b;
      r_s1_v    <= r_s0_v;
      r_s1_conj <= r_s0_conj;
      r_rr      <= w_rr;
      r_ii      <= w_ii;
      r_ri      <= w_ri;
      r_ir      <= w_ir;
      r_s2_v    <= r_s1_v;
      r_re2     <= w_re2;
      r_im2     <= w_im2;
      r_s3_v    <= r_s2_v;
      r_res     <= {w_re_q, w_im_q};
      r_ovf     <= w_ovf3;
    end
  end

  // clr wins over a same-edge set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (clr) begin
      r_sticky <= 1'b0;
    end else if (r_s3_v && out_ready && r_ovf) begin
      r_sticky <= 1'b1;
    end
  end

  assign out_valid  = r_s3_v;
  assign result     = r_res;
  assign ovf        = r_ovf;
  assign ovf_sticky = r_sticky;

endmodule
